// File: rtl/dest_ip_table_ctrl_if.sv
// rtl/dest_ip_table_ctrl_if.sv - host table port, lookup port and statistics bundle
interface dest_ip_table_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          tbl_rd_req;
  logic          tbl_wr_req;
  logic [AW-1:0] tbl_rd_addr;
  logic [AW-1:0] tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic [DW-1:0] tbl_rd_data;
  logic          tbl_rd_ack;
  logic          tbl_wr_ack;
  logic          lkp_req;
  logic [DW-1:0] lkp_ip;
  logic          lkp_ready;
  logic          lkp_done;
  logic          lkp_hit;
  logic [AW-1:0] lkp_index;
  logic          counter_clear;
  logic [DW-1:0] dest_hit_count;
  logic [DW-1:0] dest_miss_count;

  modport master (
    output tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
           lkp_req, lkp_ip, counter_clear,
    input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack, lkp_ready, lkp_done, lkp_hit,
           lkp_index, dest_hit_count, dest_miss_count
  );

  modport slave (
    input  tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
           lkp_req, lkp_ip, counter_clear,
    output tbl_rd_data, tbl_rd_ack, tbl_wr_ack, lkp_ready, lkp_done, lkp_hit,
           lkp_index, dest_hit_count, dest_miss_count
  );
endinterface

// File: rtl/dest_ip_table_ctrl.sv
// rtl/dest_ip_table_ctrl.sv - destination-IP table with host/lookup slot sharing
// One table access per cycle; the linear scan yields its slot to a host request after HOST_MAX_WAIT cycles.
module dest_ip_table_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int HOST_MAX_WAIT      = 4
) (
  input logic                 AXI_ACLK,
  input logic                 AXI_RESET,
  dest_ip_table_ctrl_if.slave bus
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = TBL_ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_IDX = '1;
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [3:0]    WAIT_MAX = 4'(HOST_MAX_WAIT);
  localparam logic [3:0]    WAIT_ONE = 4'd1;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] table_q [DEPTH];
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] ip_q, ip_d;
  logic [3:0]    wait_q, wait_d;

  logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [AW-1:0] rd_addr_q, wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          rd_latch, wr_latch;

  logic          rd_ack_q, wr_ack_q;
  logic [DW-1:0] rd_data_q;
  logic          done_q, done_d, hit_q, hit_d;
  logic [AW-1:0] lidx_q, lidx_d;
  logic [DW-1:0] hit_cnt_q, miss_cnt_q;

  logic          host_slot, svc_wr, svc_rd, scan_adv, match;
  logic [DW-1:0] entry;

  always_comb begin
    host_slot = 1'b0;
    if (rd_pend_q || wr_pend_q)
      host_slot = (state_q == IDLE) || (wait_q == WAIT_MAX);
    svc_wr   = host_slot && wr_pend_q;
    svc_rd   = host_slot && !wr_pend_q && rd_pend_q;
    scan_adv = (state_q == SCAN) && !host_slot;
    entry    = table_q[idx_q];
    // zero entries are empty slots and must never match, even for lkp_ip == 0
    match    = (entry != '0) && (entry == ip_q);

    // a pulse landing in its own service cycle becomes the next pending request
    wr_latch  = bus.tbl_wr_req && (!wr_pend_q || svc_wr);
    rd_latch  = bus.tbl_rd_req && (!rd_pend_q || svc_rd);
    wr_pend_d = svc_wr ? bus.tbl_wr_req : (wr_pend_q || bus.tbl_wr_req);
    rd_pend_d = svc_rd ? bus.tbl_rd_req : (rd_pend_q || bus.tbl_rd_req);

    wait_d = '0;
    if ((rd_pend_q || wr_pend_q) && (state_q == SCAN) && !host_slot)
      wait_d = wait_q + WAIT_ONE;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ip_d    = ip_q;
    done_d  = 1'b0;
    hit_d   = hit_q;
    lidx_d  = lidx_q;
    case (state_q)
      IDLE: begin
        if (bus.lkp_req) begin
          ip_d    = bus.lkp_ip;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_adv) begin
          if (match) begin
            state_d = IDLE;
            done_d  = 1'b1;
            hit_d   = 1'b1;
            lidx_d  = idx_q;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            hit_d   = 1'b0;
            lidx_d  = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ip_q       <= '0;
      wait_q     <= '0;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      lidx_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ip_q      <= ip_d;
      wait_q    <= wait_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      if (rd_latch) rd_addr_q <= bus.tbl_rd_addr;
      if (wr_latch) begin
        wr_addr_q <= bus.tbl_wr_addr;
        wr_data_q <= bus.tbl_wr_data;
      end
      if (svc_wr) table_q[wr_addr_q] <= wr_data_q;
      if (svc_rd) rd_data_q <= table_q[rd_addr_q];
      rd_ack_q <= svc_rd;
      wr_ack_q <= svc_wr;
      done_q   <= done_d;
      hit_q    <= hit_d;
      lidx_q   <= lidx_d;
      if (bus.counter_clear) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else if (done_d && hit_d) begin
        hit_cnt_q <= hit_cnt_q + CNT_ONE;
      end else if (done_d) begin
        miss_cnt_q <= miss_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.tbl_rd_data     = rd_data_q;
  assign bus.tbl_rd_ack      = rd_ack_q;
  assign bus.tbl_wr_ack      = wr_ack_q;
  assign bus.lkp_ready       = (state_q == IDLE);
  assign bus.lkp_done        = done_q;
  assign bus.lkp_hit         = hit_q;
  assign bus.lkp_index       = lidx_q;
  assign bus.dest_hit_count  = hit_cnt_q;
  assign bus.dest_miss_count = miss_cnt_q;
endmodule

// File: doc/dest_ip_table_ctrl.md
Name: dest_ip_table_ctrl

Overview:
- Owns the 32-entry x 32-bit destination-IP table in the output-port-lookup pcore and time-shares its single access slot per cycle.
- Two requesters share the slot: the host register path (read/write with one-cycle ack pulses) and the datapath lookup engine.
- The lookup engine submits a destination IP. The block scans the table one entry per cycle and returns hit/miss plus the matching index.
- It also maintains the hit and miss statistics counters.

Parameters:
C_S_AXI_DATA_WIDTH, 32, table entry, host data and counter width
TBL_ADDR_WIDTH, 5, table index width; depth is 2**TBL_ADDR_WIDTH (32)
HOST_MAX_WAIT, 4, max consecutive scan cycles a pending host request waits before taking the slot (1..15)

Ports:
AXI_ACLK  in  1  clock
AXI_RESET  in  1  asynchronous reset, active-high
tbl_rd_req  in  1  host read request, single-cycle pulse
tbl_wr_req  in  1  host write request, single-cycle pulse
tbl_rd_addr  in  TBL_ADDR_WIDTH  host read index, sampled with tbl_rd_req
tbl_wr_addr  in  TBL_ADDR_WIDTH  host write index, sampled with tbl_wr_req
tbl_wr_data  in  C_S_AXI_DATA_WIDTH  host write value, sampled with tbl_wr_req
tbl_rd_data  out  C_S_AXI_DATA_WIDTH  read value, valid while tbl_rd_ack=1
tbl_rd_ack  out  1  one-cycle pulse, read serviced
tbl_wr_ack  out  1  one-cycle pulse, write serviced
lkp_req  in  1  lookup start, accepted only when lkp_ready=1
lkp_ip  in  C_S_AXI_DATA_WIDTH  IP to match, sampled with an accepted lkp_req
lkp_ready  out  1  high iff scan FSM is IDLE
lkp_done  out  1  one-cycle pulse, result valid
lkp_hit  out  1  1 = match found, valid with lkp_done
lkp_index  out  TBL_ADDR_WIDTH  matching index on hit, 0 on miss
counter_clear  in  1  synchronous clear of both counters
dest_hit_count  out  C_S_AXI_DATA_WIDTH  completed lookups with hit
dest_miss_count  out  C_S_AXI_DATA_WIDTH  completed lookups with miss

Behaviour:
Reset (async, AXI_RESET=1):
- All table entries become 0.
- All outputs become 0, except lkp_ready, which is 1.
- Scan FSM goes to IDLE; pending host flags and the wait counter clear.
- A scan in progress is abandoned with no lkp_done.

Host requests:
- Each request pulse sets a pending flag and latches its address/data.
- A repeat pulse of the same type while that flag is pending is dropped. It generates no ack.

Slot arbitration, evaluated each cycle, one table access per cycle:
- Scan FSM IDLE: host gets the slot. If both host flags are pending, the write goes first and the read follows next cycle.
- Scan FSM SCAN and a host request pending: the wait counter increments each scan cycle. When it reaches HOST_MAX_WAIT, the next slot goes to the host; the scan stalls that cycle and does not advance its index. The counter then clears.
- No host request pending: the wait counter holds at 0.

Host service:
- The slot's access happens at that cycle's edge.
- The ack is registered and goes high the following cycle for exactly one cycle.
- tbl_rd_data updates together with tbl_rd_ack and holds until the next read.
- A request pulse arriving in the service cycle itself is latched as a new pending request.

Scan FSM:
- IDLE: an accepted lkp_req latches lkp_ip, sets index=0 and moves to SCAN.
- SCAN: each granted cycle reads entry[index] combinationally.
  - Entries equal to 0 are invalid and never match.
  - Match: go to IDLE. Registered outputs: lkp_done=1, lkp_hit=1, lkp_index=index; dest_hit_count increments.
  - No match at index 31: go to IDLE with lkp_done=1, lkp_hit=0, lkp_index=0; dest_miss_count increments.
  - Otherwise index increments.
- The lowest matching index wins.
- Latency with no host interference: a hit at index k gives lkp_done k+1 cycles after the accept edge; a miss gives it 32 cycles after. Each stolen slot adds 1 cycle.
- lkp_ready is 1 in the same cycle as lkp_done, so back-to-back lookups are allowed.

Writes during a scan:
- A host write that takes a stolen slot is visible to later scan reads.
- Entries already passed are not rescanned.

Counters:
- Wrap at 2^32.
- counter_clear has priority over a same-cycle increment; the result is 0.

Test Plan:
1. Reset, then host writes 0x0A000001 to index 7 and reads index 7 -> tbl_wr_ack pulses 1 cycle after the write pulse; tbl_rd_ack pulses with tbl_rd_data=0x0A000001.
2. Entries 3 and 9 = 0xC0A80101, lkp_ip=0xC0A80101 -> lkp_done 4 cycles after accept, lkp_hit=1, lkp_index=3, dest_hit_count=1.
3. lkp_ip=0 on the freshly reset table -> lkp_done after 32 cycles, lkp_hit=0, lkp_index=0, dest_miss_count=1.
4. Miss scan with HOST_MAX_WAIT=4 and a host read pulsed 1 cycle after accept -> read acked after 4 scan cycles; lookup done after 33 cycles.
5. tbl_wr_req and tbl_rd_req in the same cycle while IDLE, same address -> wr_ack first, rd_ack next cycle returning the new data. A second rd pulse while pending -> no extra ack.
6. Assert AXI_RESET at scan index 10 -> no lkp_done, lkp_ready=1 at once, table reads 0; counter_clear concurrent with a hit completion -> dest_hit_count=0.
